// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter blocks.
//   rx_state_t     : receiver FSM states
//   PAR_EVEN/ODD   : parity-mode constants
//   mid_point()    : mid-bit sample index for a given clocks-per-bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    function automatic int unsigned mid_point(input int unsigned clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser for the raw serial line plus a 3-tap history used
// for mid-bit majority voting. All flops reset to 1 so the line reads idle.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   line : raw serial input, asynchronous to clk
//   rxs  : synchronised line value
//   vote : 2-of-3 majority of rxs over the current and two previous cycles
module uart_rx_sync_vote (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic rxs,
    output logic vote
);

    logic meta;
    logic sync;
    logic tap1;
    logic tap2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            tap1 <= 1'b1;
            tap2 <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
            tap1 <= sync;
            tap2 <= tap1;
        end
    end

    assign rxs  = sync;
    assign vote = (sync & tap1) | (sync & tap2) | (tap1 & tap2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// majority-voted mid-bit sampling, parity/framing error flags and line-break
// detection.
//   Clock         : system clock, rising edge
//   Reset         : asynchronous active-high reset
//   Input_Serial  : raw serial line, idle high
//   RX_Valid      : one-cycle pulse, frame received (RX_Data and flags valid)
//   RX_Data       : received word, held until the next RX_Valid
//   Parity_Error  : pulses with RX_Valid on parity mismatch
//   Framing_Error : pulses with RX_Valid when any stop bit was low
//   Break_Detect  : one-cycle pulse when an all-zero frame is seen
//   RX_Busy       : high whenever the FSM is not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Input_Serial,
    output logic                 RX_Valid,
    output logic [DATA_BITS-1:0] RX_Data,
    output logic                 Parity_Error,
    output logic                 Framing_Error,
    output logic                 Break_Detect,
    output logic                 RX_Busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned MID   = mid_point(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam bit               PAR_MODE = PARITY_ODD ? PAR_ODD : PAR_EVEN;

    rx_state_t state_q;
    rx_state_t state_d;

    logic                 rxs;
    logic                 vote;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] data_sh;
    logic                 par_bit;
    logic                 stop_low;
    logic                 stop_high;

    logic decide;
    logic bit_end;
    logic stop_last;
    logic complete;
    logic frame_break;
    logic par_err;
    logic frm_err;

    uart_rx_sync_vote u_sync_vote (
        .clk  (Clock),
        .rst  (Reset),
        .line (Input_Serial),
        .rxs  (rxs),
        .vote (vote)
    );

    assign decide    = (cnt == CNT_DEC);
    assign bit_end   = (cnt == CNT_LAST);
    assign stop_last = (STOP_BITS == 1) || stop_idx;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rxs) state_d = START_BIT;
            end
            START_BIT: begin
                if (decide && vote) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA_BIT;
                end
            end
            DATA_BIT: begin
                if (bit_end && idx == IDX_LAST) begin
                    if (PARITY_EN) state_d = PARITY_BIT;
                    else           state_d = STOP_BIT;
                end
            end
            PARITY_BIT: begin
                if (bit_end) state_d = STOP_BIT;
            end
            STOP_BIT: begin
                // Final stop bit completes at mid-bit so a back-to-back
                // start edge is seen from IDLE.
                if (decide && stop_last) begin
                    if (frame_break) state_d = BREAK_WAIT;
                    else             state_d = IDLE;
                end
            end
            BREAK_WAIT: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / status decode
    always_comb begin
        RX_Busy     = (state_q != IDLE);
        complete    = (state_q == STOP_BIT) && decide && stop_last;
        // vote here is the final stop bit's majority, still combinational
        frame_break = (data_sh == '0) && !(PARITY_EN && par_bit) && !stop_high && !vote;
        par_err     = PARITY_EN && (par_bit != ((^data_sh) ^ PAR_MODE));
        frm_err     = stop_low || !vote;
    end

    // Bit timing, data capture and registered output pulses
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt           <= '0;
            idx           <= '0;
            stop_idx      <= 1'b0;
            data_sh       <= '0;
            par_bit       <= 1'b0;
            stop_low      <= 1'b0;
            stop_high     <= 1'b0;
            RX_Valid      <= 1'b0;
            RX_Data       <= '0;
            Parity_Error  <= 1'b0;
            Framing_Error <= 1'b0;
            Break_Detect  <= 1'b0;
        end else begin
            RX_Valid      <= complete && !frame_break;
            Parity_Error  <= complete && !frame_break && par_err;
            Framing_Error <= complete && !frame_break && frm_err;
            Break_Detect  <= complete && frame_break;
            if (complete && !frame_break) RX_Data <= data_sh;

            if (state_d != state_q || bit_end || state_q == IDLE || state_q == BREAK_WAIT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    idx       <= '0;
                    stop_idx  <= 1'b0;
                    stop_low  <= 1'b0;
                    stop_high <= 1'b0;
                end
                DATA_BIT: begin
                    if (decide)  data_sh[idx] <= vote;
                    if (bit_end) idx <= idx + 1'b1;
                end
                PARITY_BIT: begin
                    if (decide) par_bit <= vote;
                end
                STOP_BIT: begin
                    if (decide) begin
                        stop_low  <= stop_low | ~vote;
                        stop_high <= stop_high | vote;
                    end
                    if (bit_end) stop_idx <= stop_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
